rf_wb_arbiter: RTL and testbench

//  Shares the single RF write port (RFWrite/rd/rd_WriteData) between NUM_SRC writeback sources
//  (ALU, load unit, mul/div). Uses round-robin arbitration with valid/ready handshakes.

---
 rtl/rf_wb_arbiter_pkg.sv | 22 ++
 rtl/rf_wb_arbiter_rr_arbiter.sv | 65 ++++++
 rtl/rf_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_pkg
//   Shared constants for the register-file writeback arbiter.
//   WORD / REG_LOG    : CPU data width and register index width.
//   WB_NUM_SRC        : number of writeback requesters feeding the RF port.
//   wb_src_e          : fixed source slot assignment (ALU, load unit, mul/div).
// ---------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

   localparam int WORD       = 32;
   localparam int REG_LOG    = 5;

   localparam int WB_NUM_SRC = 3;

   // Slot index of each writeback requester on the arbiter inputs.
   typedef enum logic [1:0] {
      WB_SRC_ALU = 2'd0,
      WB_SRC_LSU = 2'd1,
      WB_SRC_MDU = 2'd2
   } wb_src_e;

endpackage : rf_wb_arbiter_pkg

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. Scans req cyclically starting at ptr and
//   grants the first requester found. The pointer is owned by the caller.
//   A pointer value >= N (possible only when N is not a power of two) is
//   treated as 0.
// Ports
//   req_i   in   N       request vector
//   ptr_i   in   PTR_W   highest-priority index for this cycle
//   gnt_o   out  N       one-hot grant, all zero when no request
//   gidx_o  out  PTR_W   binary index of the granted requester (0 if none)
//   any_o   out  1       at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 3,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [PTR_W-1:0] gidx_o,
   output logic             any_o
);

   // One extra bit so start + k never overflows before the wrap subtraction.
   localparam int IW = PTR_W + 1;

   logic          found;
   logic [IW-1:0] start;
   logic [IW-1:0] idx;

   always_comb begin
      found  = 1'b0;
      start  = '0;
      idx    = '0;
      gidx_o = '0;
      gnt_o  = '0;

      if ({1'b0, ptr_i} < IW'(N)) begin
         start = {1'b0, ptr_i};
      end

      for (int k = 0; k < N; k++) begin
         idx = start + IW'(k);
         if (idx >= IW'(N)) begin
            idx = idx - IW'(N);
         end
         // Compare against each constant slot instead of indexing by idx,
         // which keeps the select widths exact for any N.
         for (int j = 0; j < N; j++) begin
            if (!found && (idx == IW'(j)) && req_i[j]) begin
               found  = 1'b1;
               gidx_o = PTR_W'(j);
            end
         end
      end

      for (int j = 0; j < N; j++) begin
         gnt_o[j] = found && (gidx_o == PTR_W'(j));
      end
   end

   assign any_o = found;

endmodule : rr_arbiter

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single register-file write port between NUM_SRC writeback
//   sources using round-robin arbitration. A transfer happens when a source's
//   valid and ready are both high; the RF never back-pressures, so every
//   grant completes in the cycle it is issued. Transfers to r0 are granted
//   and counted but never raise rf_we.
//
//   Handshake: src_valid[i] is raised with a stable payload (src_rd/src_data
//   slice i) and held until src_ready[i] is seen high; src_ready is one-hot,
//   only ever high on a valid source, and the transfer is valid & ready on
//   the posedge.
//
//   Build option RF_WB_OUTREG_EN:
//     defined   - rf_we/rf_rd/rf_wdata registered, one cycle after transfer.
//     undefined - RF outputs combinational from the grant (RF commits on the
//                 negedge of the grant cycle).
//
// Ports
//   clk        in   1               clock, posedge
//   rst        in   1               synchronous active-high reset
//   src_valid  in   NUM_SRC         per-source request
//   src_rd     in   NUM_SRC*REG_W   per-source destination register
//   src_data   in   NUM_SRC*WORD_W  per-source write data
//   src_ready  out  NUM_SRC         one-hot grant
//   rf_we      out  1               RF write enable
//   rf_rd      out  REG_W           RF destination register
//   rf_wdata   out  WORD_W          RF write data
//   grant_cnt  out  32              accepted transfers, wraps at 2^32
// ---------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = WB_NUM_SRC,
   parameter int PTR_W   = 2,
   parameter int WORD_W  = WORD,
   parameter int REG_W   = REG_LOG
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*REG_W-1:0]  src_rd,
   input  logic [NUM_SRC*WORD_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      rf_we,
   output logic [REG_W-1:0]          rf_rd,
   output logic [WORD_W-1:0]         rf_wdata,
   output logic [31:0]               grant_cnt
);

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [31:0]        grant_cnt_q, grant_cnt_d;

   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] gnt;
   logic [PTR_W-1:0]   gidx;
   logic               xfer;

   logic [REG_W-1:0]   sel_rd;
   logic [WORD_W-1:0]  sel_data;
   logic               we_c;
   logic [REG_W-1:0]   rd_c;
   logic [WORD_W-1:0]  wdata_c;

   // Masking the requests during reset removes any grant, so no transfer
   // can happen in a reset cycle even with requests pending.
   assign req = rst ? '0 : src_valid;

   rr_arbiter #(
      .N     (NUM_SRC),
      .PTR_W (PTR_W)
   ) u_rr (
      .req_i  (req),
      .ptr_i  (ptr_q),
      .gnt_o  (gnt),
      .gidx_o (gidx),
      .any_o  (xfer)
   );

   assign src_ready = gnt;

   // Payload mux of the granted source.
   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (gidx == PTR_W'(j)) begin
            sel_rd   = src_rd[j*REG_W +: REG_W];
            sel_data = src_data[j*WORD_W +: WORD_W];
         end
      end
   end

   // r0 writes are consumed here; the RF sees nothing.
   always_comb begin
      we_c    = xfer && (sel_rd != '0);
      rd_c    = we_c ? sel_rd   : '0;
      wdata_c = we_c ? sel_data : '0;
   end

   // Pointer moves to the slot after the winner, wrapping at NUM_SRC-1.
   always_comb begin
      ptr_d       = ptr_q;
      grant_cnt_d = grant_cnt_q;
      if (xfer) begin
         ptr_d       = (gidx == PTR_W'(NUM_SRC-1)) ? '0 : gidx + PTR_W'(1);
         grant_cnt_d = grant_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         grant_cnt_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign grant_cnt = grant_cnt_q;

`ifdef RF_WB_OUTREG_EN
   logic               rf_we_q;
   logic [REG_W-1:0]   rf_rd_q;
   logic [WORD_W-1:0]  rf_wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q    <= we_c;
         rf_rd_q    <= rd_c;
         rf_wdata_q <= wdata_c;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;
`else
   assign rf_we    = we_c;
   assign rf_rd    = rd_c;
   assign rf_wdata = wdata_c;
`endif

endmodule : rf_wb_arbiter

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Directed bench for rf_wb_arbiter (NUM_SRC=3). Inputs are driven 1ns after
//   posedge; src_ready is sampled on the negedge. RF outputs are sampled on
//   the negedge of the grant cycle (combinational build) or 1ns after the
//   following posedge (RF_WB_OUTREG_EN build).
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int RW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_valid;
  logic [N*RW-1:0] src_rd;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            rf_we;
  logic [RW-1:0]   rf_rd;
  logic [DW-1:0]   rf_wdata;
  logic [31:0]     grant_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .src_ready (src_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .grant_cnt (grant_cnt)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];
  logic       prev_we  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] v,
                       input logic [4:0] r0, input logic [31:0] d0,
                       input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2);
    src_valid = v;
    src_rd    = {r2, r1, r0};
    src_data  = {d2, d1, d0};
  endtask

  // One clock cycle with the currently driven inputs; checks the grant and
  // the RF write expected from it.
  task automatic cycle(input string tag, input logic [2:0] er, input logic ew,
                       input logic [4:0] erd, input logic [31:0] ed);
    @(negedge clk);
    check_eq({tag, ".ready"}, 64'(src_ready), 64'(er));
`ifdef RF_WB_OUTREG_EN
    check_eq({tag, ".we_lag"}, 64'(rf_we), 64'(prev_we));
    @(posedge clk);
    #1;
    check_eq({tag, ".we"},    64'(rf_we),    64'(ew));
    check_eq({tag, ".rd"},    64'(rf_rd),    64'(erd));
    check_eq({tag, ".wdata"}, 64'(rf_wdata), 64'(ed));
    prev_we = ew;
`else
    check_eq({tag, ".we"},    64'(rf_we),    64'(ew));
    check_eq({tag, ".rd"},    64'(rf_rd),    64'(erd));
    check_eq({tag, ".wdata"}, 64'(rf_wdata), 64'(ed));
    @(posedge clk);
    #1;
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] g;

    // Reset held 3 cycles with every source requesting.
    rst = 1'b1;
    drive(3'b111, 5'd1, 32'hA0, 5'd2, 32'hA1, 5'd3, 32'hA2);
    repeat (3) cycle("rst_hold", 3'b000, 1'b0, 5'd0, 32'd0);
    check_eq("rst_cnt", 64'(grant_cnt), 64'd0);

    // First grant after reset goes to src0.
    rst = 1'b0;
    cycle("first_grant", 3'b001, 1'b1, 5'd1, 32'hA0);
    check_eq("first_cnt", 64'(grant_cnt), 64'd1);

    // Single source: src1, rd=5.
    drive(3'b010, 5'd0, 32'd0, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    cycle("single", 3'b010, 1'b1, 5'd5, 32'hDEADBEEF);
    check_eq("single_cnt", 64'(grant_cnt), 64'd2);

    // Pointer now at 2: with all valid, src2 wins.
    drive(3'b111, 5'd1, 32'hA0, 5'd2, 32'hA1, 5'd3, 32'hA2);
    cycle("ptr2_pick", 3'b100, 1'b1, 5'd3, 32'hA2);

    // Fairness: all valid for 6 cycles -> 0,1,2,0,1,2.
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      cycle("fair", 3'b001 << g, 1'b1, 5'(g) + 5'd1, 32'hA0 + 32'(g));
    end
    check_eq("fair_cnt", 64'(grant_cnt), 64'd9);

    // r0 destination: granted and counted, no RF write.
    drive(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'h1234);
    cycle("r0_drop", 3'b100, 1'b0, 5'd0, 32'd0);
    check_eq("r0_cnt", 64'(grant_cnt), 64'd10);

    // Idle: nothing granted, counter holds.
    drive(3'b000, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h3);
    cycle("idle", 3'b000, 1'b0, 5'd0, 32'd0);
    check_eq("idle_cnt", 64'(grant_cnt), 64'd10);

    // Move pointer to 2, then reset with src0/src2 pending.
    drive(3'b010, 5'd0, 32'd0, 5'd4, 32'h44, 5'd0, 32'd0);
    cycle("to_ptr2", 3'b010, 1'b1, 5'd4, 32'h44);
    check_eq("to_ptr2_cnt", 64'(grant_cnt), 64'd11);
    rst = 1'b1;
    drive(3'b101, 5'd6, 32'h66, 5'd0, 32'd0, 5'd7, 32'h77);
    cycle("mid_rst", 3'b000, 1'b0, 5'd0, 32'd0);
    check_eq("mid_rst_cnt", 64'(grant_cnt), 64'd0);

    // After release arbitration restarts from 0.
    rst = 1'b0;
    cycle("post_rst_a", 3'b001, 1'b1, 5'd6, 32'h66);
    drive(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 32'h77);
    cycle("post_rst_b", 3'b100, 1'b1, 5'd7, 32'h77);
    check_eq("post_rst_cnt", 64'(grant_cnt), 64'd2);

    // Same rd from two sources: serialized in RR order.
    drive(3'b011, 5'd9, 32'h111, 5'd9, 32'h222, 5'd0, 32'd0);
    cycle("same_rd_a", 3'b001, 1'b1, 5'd9, 32'h111);
    drive(3'b010, 5'd0, 32'd0, 5'd9, 32'h222, 5'd0, 32'd0);
    cycle("same_rd_b", 3'b010, 1'b1, 5'd9, 32'h222);

    // Pointer at 2, only src0 requests: scan wraps to src0.
    drive(3'b001, 5'd8, 32'h88, 5'd0, 32'd0, 5'd0, 32'd0);
    cycle("wrap", 3'b001, 1'b1, 5'd8, 32'h88);
    check_eq("wrap_cnt", 64'(grant_cnt), 64'd5);

    drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    cycle("drain", 3'b000, 1'b0, 5'd0, 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rf_wb_arbiter
